// File: rtl/pipeline_if_id_if.sv
`default_nettype none
// ============================================================================
// pipeline_if_id_if : fetch/decode boundary bundle for the IF/ID register
// Rev 1.0
// ============================================================================
interface pipeline_if_id_if #(
   parameter int CNT_W = 32
);
   logic [31:0]      PC_in_IFID;
   logic [31:0]      inst_in_IFID;
   logic             en_IFID;
   logic             flush_IFID;
   logic [31:0]      PC_out_IFID;
   logic [31:0]      inst_out_IFID;
   logic             valid_IFID;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output PC_in_IFID, inst_in_IFID, en_IFID, flush_IFID,
      input  PC_out_IFID, inst_out_IFID, valid_IFID, stall_cnt, flush_cnt
   );

   modport slave (
      input  PC_in_IFID, inst_in_IFID, en_IFID, flush_IFID,
      output PC_out_IFID, inst_out_IFID, valid_IFID, stall_cnt, flush_cnt
   );
endinterface
`default_nettype wire

// File: rtl/pipeline_if_id.sv
`default_nettype none
// ============================================================================
// pipeline_if_id : IF/ID pipeline register with stall skid copy, flush
//                  bubbles and saturating stall/flush event counters
// Rev 1.0
// ============================================================================
module pipeline_if_id #(
   parameter logic [31:0] NOP_INST = 32'h00000013,
   parameter int          CNT_W    = 32
) (
   input  wire               clk_IFID,
   input  wire               rst_IFID,
   pipeline_if_id_if.slave   bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [31:0]      pc_q;
   logic             valid_q;
   logic [31:0]      hold_q;
   logic             held_q;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   always_ff @(posedge clk_IFID or posedge rst_IFID) begin
      if (rst_IFID) begin
         pc_q        <= 32'h0;
         valid_q     <= 1'b0;
         hold_q      <= 32'h0;
         held_q      <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (bus.flush_IFID) begin
            pc_q    <= bus.PC_in_IFID;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
         end else if (bus.en_IFID) begin
            pc_q    <= bus.PC_in_IFID;
            valid_q <= 1'b1;
            held_q  <= 1'b0;
         end else if (valid_q && !held_q) begin
            // Fetch PC is frozen, so memory data moves on next cycle: keep a copy.
            hold_q <= bus.inst_in_IFID;
            held_q <= 1'b1;
         end

         if (!bus.flush_IFID && !bus.en_IFID && valid_q && (stall_cnt_q != CNT_MAX))
            stall_cnt_q <= stall_cnt_q + 1'b1;
         if (bus.flush_IFID && (flush_cnt_q != CNT_MAX))
            flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign bus.PC_out_IFID   = pc_q;
   assign bus.valid_IFID    = valid_q;
   assign bus.inst_out_IFID = !valid_q ? NOP_INST : (held_q ? hold_q : bus.inst_in_IFID);
   assign bus.stall_cnt     = stall_cnt_q;
   assign bus.flush_cnt     = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_if_id.sv
`default_nettype none
// ============================================================================
// tb_pipeline_if_id : directed + randomized bench for pipeline_if_id
// Rev 1.0
// ============================================================================
module tb_pipeline_if_id;

   localparam int          CNT_W   = 4;
   localparam int          CNT_SAT = (1 << CNT_W) - 1;
   localparam logic [31:0] NOP     = 32'h00000013;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pipeline_if_id_if #(.CNT_W(CNT_W)) bus ();

   pipeline_if_id #(.NOP_INST(NOP), .CNT_W(CNT_W)) dut (
      .clk_IFID (clk),
      .rst_IFID (rst),
      .bus      (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;

   // Instruction memory contents: explicit entries, hashed fallback elsewhere.
   logic [31:0] mem [logic [31:0]];
   logic [31:0] junk;
   bit          fixed_junk = 1'b0;

   function automatic logic [31:0] memval(input logic [31:0] pc);
      if (mem.exists(pc)) return mem[pc];
      return (pc * 32'h9E3779B1) ^ 32'hA5A50000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: what decode must see, in terms of PCs and counts.
   bit          m_valid;
   logic [31:0] m_pc;
   int          m_sc, m_fc;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid = 1'b0; m_pc = 32'h0; m_sc = 0; m_fc = 0;
      end else if (bus.flush_IFID) begin
         m_valid = 1'b0; m_pc = bus.PC_in_IFID;
         if (m_fc < CNT_SAT) m_fc++;
      end else if (bus.en_IFID) begin
         m_valid = 1'b1; m_pc = bus.PC_in_IFID;
      end else if (m_valid && m_sc < CNT_SAT) begin
         m_sc++;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("model_pc",    bus.PC_out_IFID, m_pc);
         chk("model_valid", {31'h0, bus.valid_IFID}, {31'h0, m_valid});
         chk("model_inst",  bus.inst_out_IFID, m_valid ? memval(m_pc) : NOP);
         chk("model_scnt",  {28'h0, bus.stall_cnt}, m_sc);
         chk("model_fcnt",  {28'h0, bus.flush_cnt}, m_fc);
      end
   end

   // One clock: present inputs, take the edge, then drive the memory's answer.
   task automatic cyc(input logic en, input logic fl, input logic [31:0] pc);
      bit adv;
      bus.PC_in_IFID = pc;
      bus.en_IFID    = en;
      bus.flush_IFID = fl;
      adv = en && !fl;
      @(posedge clk);
      #1;
      if (adv)             bus.inst_in_IFID = memval(pc);
      else if (fixed_junk) bus.inst_in_IFID = junk;
      else                 bus.inst_in_IFID = $urandom;
      #1;
   endtask

   task automatic pulse_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_pc",    bus.PC_out_IFID, 32'h0);
      chk("rst_inst",  bus.inst_out_IFID, NOP);
      chk("rst_valid", {31'h0, bus.valid_IFID}, 32'h0);
      chk("rst_scnt",  {28'h0, bus.stall_cnt}, 32'h0);
      chk("rst_fcnt",  {28'h0, bus.flush_cnt}, 32'h0);
      #1 rst = 1'b0;
   endtask

   initial begin
      logic [31:0] pc;
      int          r;
      mem[32'h00] = 32'h000000A0; mem[32'h04] = 32'h000000A4;
      mem[32'h08] = 32'h000000A8; mem[32'h10] = 32'h11111111;
      mem[32'h14] = 32'h14141414; mem[32'h20] = 32'h20202020;
      mem[32'h28] = 32'h28282828;
      bus.PC_in_IFID = 32'h0; bus.inst_in_IFID = 32'h0;
      bus.en_IFID = 1'b0; bus.flush_IFID = 1'b0;

      // Leave the bus dirty, then reset mid-cycle.
      cyc(1, 0, 32'h40); cyc(0, 1, 32'h44);
      pulse_reset();
      chk_on = 1'b1;

      // Streaming
      cyc(1, 0, 32'h0);
      chk("str0_pc", bus.PC_out_IFID, 32'h0); chk("str0_inst", bus.inst_out_IFID, 32'hA0);
      cyc(1, 0, 32'h4);
      chk("str1_pc", bus.PC_out_IFID, 32'h4); chk("str1_inst", bus.inst_out_IFID, 32'hA4);
      cyc(1, 0, 32'h8);
      chk("str2_pc", bus.PC_out_IFID, 32'h8); chk("str2_inst", bus.inst_out_IFID, 32'hA8);
      chk("str_valid", {31'h0, bus.valid_IFID}, 32'h1);
      chk("str_scnt",  {28'h0, bus.stall_cnt}, 32'h0);

      // Stall three cycles while memory output changes
      cyc(1, 0, 32'h10);
      junk = 32'h22222222; fixed_junk = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 32'h14);
         chk("stall_pc",   bus.PC_out_IFID, 32'h10);
         chk("stall_inst", bus.inst_out_IFID, 32'h11111111);
      end
      chk("stall_scnt", {28'h0, bus.stall_cnt}, 32'h3);
      fixed_junk = 1'b0;
      cyc(1, 0, 32'h14);
      chk("release_pc",   bus.PC_out_IFID, 32'h14);
      chk("release_inst", bus.inst_out_IFID, 32'h14141414);

      // Flush while 0x20 is live
      cyc(1, 0, 32'h20);
      cyc(1, 1, 32'h24);
      chk("flush_valid", {31'h0, bus.valid_IFID}, 32'h0);
      chk("flush_inst",  bus.inst_out_IFID, NOP);
      chk("flush_fcnt",  {28'h0, bus.flush_cnt}, 32'h1);
      cyc(1, 0, 32'h28);
      chk("refill_valid", {31'h0, bus.valid_IFID}, 32'h1);
      chk("refill_inst",  bus.inst_out_IFID, 32'h28282828);

      // Flush with en=0 while HELD
      cyc(0, 0, 32'h2C);
      cyc(0, 1, 32'h2C);
      chk("fstall_valid", {31'h0, bus.valid_IFID}, 32'h0);
      chk("fstall_inst",  bus.inst_out_IFID, NOP);
      chk("fstall_scnt",  {28'h0, bus.stall_cnt}, 32'h4);
      chk("fstall_fcnt",  {28'h0, bus.flush_cnt}, 32'h2);

      // Saturation of stall counter
      cyc(1, 0, 32'h30);
      for (int i = 0; i < 20; i++) cyc(0, 0, 32'h34);
      chk("sat_scnt", {28'h0, bus.stall_cnt}, 32'hF);

      // Reset released mid-stall restarts empty
      pulse_reset();
      cyc(0, 0, 32'h34);
      chk("post_rst_valid", {31'h0, bus.valid_IFID}, 32'h0);
      cyc(1, 0, 32'h38);
      chk("post_rst_pc", bus.PC_out_IFID, 32'h38);

      // Randomized traffic
      pc = 32'h100;
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 99);
         if ($urandom_range(0, 3) == 0) pc = $urandom & 32'hFFFF_FFFC;
         else                           pc = pc + 32'h4;
         cyc(r < 70, r >= 88, pc);
         if ($urandom_range(0, 99) == 0) pulse_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipeline_if_id.md
# pipeline_if_id

Pipeline register between the instruction-fetch stage and decode. It captures the fetch PC each advancing cycle and aligns it with instruction data from the synchronous instruction memory, which returns data one cycle after the address. It holds a stable PC/instruction pair across stalls and injects NOP bubbles on flushes. It also keeps stall and flush event counters for performance debug.

## Interface
Parameters:
- NOP_INST, 32'h00000013, instruction driven on inst_out_IFID whenever the stage is invalid (addi x0,x0,0)
- CNT_W, 32, width of both event counters

Ports:
- clk_IFID  in  1  stage clock; all state updates on rising edge
- rst_IFID  in  1  reset, asynchronous, active-high
- PC_in_IFID  in  32  PC currently presented by fetch (fetch PC register output)
- inst_in_IFID  in  32  instruction-memory read data; valid in cycle n+1 for the address presented in cycle n
- en_IFID  in  1  advance enable from the hazard unit; 0 = stall; same net drives the fetch PC enable
- flush_IFID  in  1  squash request (taken branch/jump, same cycle PCSrc=1)
- PC_out_IFID  out  32  PC of the instruction held in this stage
- inst_out_IFID  out  32  instruction held in this stage
- valid_IFID  out  1  stage contains a real instruction
- stall_cnt  out  CNT_W  count of stall cycles with a valid instruction held
- flush_cnt  out  CNT_W  count of flush events

## Operation
- State register: pc_q[31:0], valid_q, hold_q[31:0], held_q. The FSM is encoded by {valid_q, held_q}:
  - EMPTY (0,x): bubble
  - LIVE (1,0): instruction taken straight from inst_in_IFID
  - HELD (1,1): instruction taken from hold_q
- Outputs:
  - PC_out_IFID = pc_q
  - valid_IFID = valid_q
  - inst_out_IFID = !valid_q ? NOP_INST : held_q ? hold_q : inst_in_IFID
- Per-edge priority is flush > stall > advance:
  - flush_IFID=1, regardless of en: valid_q<=0, held_q<=0, pc_q<=PC_in_IFID. Next state is EMPTY.
  - flush=0, en=1: pc_q<=PC_in_IFID, valid_q<=1, held_q<=0. Next state is LIVE.
  - flush=0, en=0, state LIVE: hold_q<=inst_in_IFID, held_q<=1. Next state is HELD. The fetch PC is frozen, so memory read data changes next cycle; the skid copy preserves the instruction.
  - flush=0, en=0, state HELD or EMPTY: no change.
- Counters:
  - stall_cnt increments on each edge with flush=0, en=0, valid_q=1.
  - flush_cnt increments on each edge with flush=1.
  - Both saturate at all-ones and do not wrap.
- Leaving HELD via advance discards hold_q. hold_q contents are don't-care when held_q=0.

## Timing
- Reset, asynchronous and immediate:
  - pc_q=0, valid_q=0, held_q=0, hold_q=0, counters=0
  - therefore PC_out_IFID=0, inst_out_IFID=NOP_INST, valid_IFID=0
- Latency is one edge. PC_in presented in cycle n appears on PC_out_IFID in cycle n+1 together with that PC's instruction data.
- inst_out_IFID is combinational from inst_in_IFID in LIVE. Every other output is registered.
- Stalls of any length return the same PC/instruction every cycle. The first advance edge after a stall releases the held instruction to decode.
- Flush in the same cycle as en=0 still bubbles. The hazard unit must not rely on the stall to keep the squashed instruction.
- Reset deasserted mid-stall restarts in EMPTY. The first advance edge loads PC_in_IFID.

## Test plan
- Reset: assert rst_IFID asynchronously mid-cycle -> outputs go immediately to PC=0, inst=0x00000013, valid=0, counters=0.
- Streaming: en=1, PC 0x0,0x4,0x8, with memory returning 0xA0,0xA4,0xA8 one cycle late -> each cycle decode sees a matching pair (PC,inst), valid=1, stall_cnt=0.
- Stall: PC 0x10/inst 0x11111111 captured, then en=0 for 3 cycles while memory switches to 0x22222222 -> outputs stay 0x10/0x11111111, stall_cnt=3; the next advance edge loads 0x14.
- Flush: flush=1 for one edge while PC 0x20 is live -> next cycle valid=0, inst=0x00000013, flush_cnt=1; the following advance restores valid=1.
- Flush during stall: state HELD, then flush=1 with en=0 -> state EMPTY, inst=NOP, stall_cnt unchanged on that edge, flush_cnt+1.
- Saturation: force 2^CNT_W stall edges (CNT_W=4 bench override) -> stall_cnt holds at 4'hF.
